multi_channel_tick_divider: RTL and testbench
=============================================

# multi_channel_tick_divider

Parametrised successor of the single-channel tick divider: NUM_CH independent channels, each dividing clock_in by a runtime-programmable modulus and producing both a one-cycle tick and a 50%-style square output. Sits between the board clock and every timebase consumer (display multiplexing, debounce, seconds counter), replacing per-consumer fixed dividers with one block loaded by the control logic.

## Interface
- NUM_BITS, 16, width of counter and modulus per channel
- NUM_CH, 4, number of channels (1..16)
- DEFAULT_MOD, 50_000, modulus loaded into every channel at reset; must be < 2**NUM_BITS
- clock_in  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-channel count enable
- sync_clear  in  1  synchronous clear of all counters/outputs
- load  in  1  modulus write strobe
- load_ch  in  clog2(NUM_CH) (min 1)  target channel of the write
- load_value  in  NUM_BITS  new modulus
- tick_out  out  NUM_CH  one-cycle pulse per period
- square_out  out  NUM_CH  toggles on every tick (period 2×modulus)
- load_err  out  1  sticky: a write had load_value==0 or load_ch>=NUM_CH

## Operation
- Per channel: active modulus mod_a, shadow modulus mod_s, counter count, pending flag.
- Reset: count=0, mod_a=mod_s=DEFAULT_MOD, pending=0, tick_out=0, square_out=0, load_err=0.
- Enabled channel: count increments; when count==mod_a-1, count→0 (wrap) and tick_out=1 for the following cycle; otherwise tick_out=0.
- square_out toggles at each wrap edge.
- Disabled channel: count, square_out, mod_a hold; tick_out forced 0.
- Write (load=1, valid): value goes to mod_s, pending=1.
  - Channel enabled: mod_a←mod_s at the next wrap edge strictly after the write edge; a write on the same edge as a wrap waits for the following wrap. Current period never shortened.
  - Channel disabled: mod_a←load_value and count←0 on the write edge, pending=0.
- Invalid write (load_value==0 or load_ch out of range): ignored, load_err←1 until reset.
- mod_a==1: tick_out high every cycle while enabled; square_out toggles every cycle.
- sync_clear: all counts→0, tick_out→0, square_out→0; pending shadows applied immediately to mod_a; load_err unchanged. A load on the same edge as sync_clear is taken directly into mod_a.
- Reset mid-operation discards pending loads.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Enable rising with count=0, modulus M: first tick_out high in the cycle after the M-th enabled edge; period exactly M cycles thereafter.
- Write-to-effect latency: 0 if channel disabled; otherwise applied at the first wrap edge after the write edge, so the first period at the new modulus starts there.
- load_err asserts the cycle after the offending write.
- Channels fully independent; a write to one channel never perturbs another's phase.

## Structure
- Package tick_div_pkg: CH_W = max(1, clog2(NUM_CH)) helper function, mod-validity check function, reset-state constants.
- Sub-module tick_div_channel (NUM_BITS, DEFAULT_MOD): one counter/shadow/tick/square; top instantiates NUM_CH in a generate loop, decodes load_ch, and owns load_err.

## Test plan
- Reset, all enabled, DEFAULT_MOD=5 -> each tick_out high on cycles 5,10,15…; square_out toggles at same edges.
- Channel 1 running mod 5, write 3 mid-period (count=2) -> current period ends at 5, next periods 3 cycles; channels 0,2,3 unchanged.
- Write 8 to channel 2 exactly on its wrap edge -> one more period of old modulus, then period 8.
- Channel 0 disabled, write 2 -> count=0 immediately; on enable, ticks every 2 cycles; write load_value=1 -> tick_out constantly high.
- Write load_value=0 and load_ch=NUM_CH -> moduli unchanged, load_err=1 next cycle, stays 1 across sync_clear.
- sync_clear with pending write on channel 3 -> all outputs 0 next cycle, channel 3 runs new modulus from count 0; reset_n pulse mid-period -> all outputs 0 asynchronously, moduli back to DEFAULT_MOD.

Source files
------------

// File: rtl/tick_div_pkg.sv
// Shared helpers and reset-state constants for the multi-channel tick divider.
package tick_div_pkg;

   localparam logic RST_TICK     = 1'b0;
   localparam logic RST_SQUARE   = 1'b0;
   localparam logic RST_PENDING  = 1'b0;
   localparam logic RST_LOAD_ERR = 1'b0;

   // Channel-select width; a single channel still gets a one-bit select port.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic logic mod_write_ok(input logic [31:0] value,
                                         input int unsigned ch,
                                         input int unsigned num_ch);
      return (value != 32'd0) && (ch < num_ch);
   endfunction

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active/shadow modulus, one-cycle tick and square output.
module tick_div_channel
   import tick_div_pkg::*;
#(
   parameter int          NUM_BITS    = 16,
   parameter int unsigned DEFAULT_MOD = 50_000
) (
   input  logic                clock_in,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                sync_clear,
   input  logic                write,
   input  logic [NUM_BITS-1:0] write_value,
   output logic                tick,
   output logic                square
);

   localparam logic [NUM_BITS-1:0] RST_MOD = NUM_BITS'(DEFAULT_MOD);
   localparam logic [NUM_BITS-1:0] ONE     = NUM_BITS'(1);

   logic [NUM_BITS-1:0] count;
   logic [NUM_BITS-1:0] mod_a;
   logic [NUM_BITS-1:0] mod_s;
   logic                pending;
   logic                wrap;

   assign wrap = (count == (mod_a - ONE));

   // A shadow written on a wrap edge stays pending until the next wrap, so the
   // running period is never cut short.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         count   <= '0;
         mod_a   <= RST_MOD;
         mod_s   <= RST_MOD;
         pending <= RST_PENDING;
         tick    <= RST_TICK;
         square  <= RST_SQUARE;
      end else if (sync_clear) begin
         count   <= '0;
         tick    <= 1'b0;
         square  <= 1'b0;
         pending <= 1'b0;
         if (write) begin
            mod_a <= write_value;
            mod_s <= write_value;
         end else if (pending) begin
            mod_a <= mod_s;
         end
      end else if (write && !enable) begin
         count   <= '0;
         mod_a   <= write_value;
         mod_s   <= write_value;
         pending <= 1'b0;
         tick    <= 1'b0;
      end else if (enable) begin
         if (wrap) begin
            count  <= '0;
            tick   <= 1'b1;
            square <= ~square;
            if (pending) begin
               mod_a <= mod_s;
            end
         end else begin
            count <= count + ONE;
            tick  <= 1'b0;
         end
         if (write) begin
            mod_s   <= write_value;
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_channel_tick_divider.sv
// NUM_CH independent programmable tick dividers sharing one modulus write port.
module multi_channel_tick_divider
   import tick_div_pkg::*;
#(
   parameter int          NUM_BITS    = 16,
   parameter int          NUM_CH      = 4,
   parameter int unsigned DEFAULT_MOD = 50_000
) (
   input  logic                            clock_in,
   input  logic                            reset_n,
   input  logic [NUM_CH-1:0]               enable,
   input  logic                            sync_clear,
   input  logic                            load,
   input  logic [ch_width(NUM_CH)-1:0]     load_ch,
   input  logic [NUM_BITS-1:0]             load_value,
   output logic [NUM_CH-1:0]               tick_out,
   output logic [NUM_CH-1:0]               square_out,
   output logic                            load_err
);

   localparam int CH_W = ch_width(NUM_CH);

   logic write_ok;

   assign write_ok = load && mod_write_ok(32'(load_value), 32'(load_ch), NUM_CH);

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         load_err <= RST_LOAD_ERR;
      end else if (load && !write_ok) begin
         load_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_div_channel #(
         .NUM_BITS    (NUM_BITS),
         .DEFAULT_MOD (DEFAULT_MOD)
      ) u_channel (
         .clock_in    (clock_in),
         .reset_n     (reset_n),
         .enable      (enable[i]),
         .sync_clear  (sync_clear),
         .write       (write_ok && (load_ch == CH_W'(i))),
         .write_value (load_value),
         .tick        (tick_out[i]),
         .square      (square_out[i])
      );
   end

endmodule

// File: tb/tb_multi_channel_tick_divider.sv
// Directed scoreboard bench for multi_channel_tick_divider (5 channels, modulus 5 at reset).
module tb_multi_channel_tick_divider;

   localparam int NCH = 5;
   localparam int NB  = 8;
   localparam logic [10:0] TICKS = 11'h01F;
   localparam logic [10:0] SQS   = 11'h3E0;
   localparam logic [10:0] ERR   = 11'h400;
   localparam logic [10:0] ALL   = 11'h7FF;

   logic           clock_in = 1'b0;
   logic           reset_n;
   logic [NCH-1:0] enable;
   logic           sync_clear;
   logic           load;
   logic [2:0]     load_ch;
   logic [NB-1:0]  load_value;
   logic [NCH-1:0] tick_out;
   logic [NCH-1:0] square_out;
   logic           load_err;
   logic [10:0]    obs;

   typedef struct {
      int          cyc;
      logic [10:0] mask;
      logic [10:0] val;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   multi_channel_tick_divider #(
      .NUM_BITS    (NB),
      .NUM_CH      (NCH),
      .DEFAULT_MOD (5)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .enable     (enable),
      .sync_clear (sync_clear),
      .load       (load),
      .load_ch    (load_ch),
      .load_value (load_value),
      .tick_out   (tick_out),
      .square_out (square_out),
      .load_err   (load_err)
   );

   assign obs = {load_err, square_out, tick_out};

   always #5 clock_in = ~clock_in;

   initial forever begin
      @(posedge clock_in);
      cyc++;
   end

   // Monitor: every cycle, pop and compare the expectations due now.
   initial forever begin
      @(negedge clock_in);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc <= cyc) begin
            n_checks++;
            if (exp_q[i].cyc < cyc) begin
               n_fail++;
               $display("FAIL %s: due cycle %0d not checked (now %0d)", exp_q[i].name, exp_q[i].cyc, cyc);
            end else if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
               n_fail++;
               $display("FAIL %s @cycle %0d: got %b, want %b (mask %b)",
                        exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val, exp_q[i].mask);
            end
            exp_q.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic exp_vec(input int c, input logic [10:0] m, input logic [10:0] v, input string nm);
      exp_t e;
      e.cyc = c; e.mask = m; e.val = v; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic exp_ch(input int c, input int ch, input logic tk, input logic sq, input string nm);
      exp_t e;
      e.cyc = c; e.mask = '0; e.val = '0; e.name = nm;
      e.mask[ch] = 1'b1; e.mask[NCH+ch] = 1'b1;
      e.val[ch]  = tk;   e.val[NCH+ch]  = sq;
      exp_q.push_back(e);
   endtask

   task automatic exp_tick(input int c, input int ch, input logic tk, input string nm);
      exp_t e;
      e.cyc = c; e.mask = '0; e.val = '0; e.name = nm;
      e.mask[ch] = 1'b1; e.val[ch] = tk;
      exp_q.push_back(e);
   endtask

   task automatic at_posedge();
      @(posedge clock_in);
      #2;
   endtask

   task automatic goto(input int t);
      while (cyc < t) at_posedge();
   endtask

   task automatic wr(input int ch, input int v);
      load       = 1'b1;
      load_ch    = 3'(ch);
      load_value = NB'(v);
   endtask

   int c0, w, x;

   initial begin
      reset_n    = 1'b0;
      enable     = '0;
      sync_clear = 1'b0;
      load       = 1'b0;
      load_ch    = '0;
      load_value = '0;

      // Reset state, then all channels enabled at modulus 5
      goto(2);
      exp_vec(2, ALL, 11'h000, "reset_state");
      reset_n = 1'b1;
      at_posedge();
      c0 = cyc;
      w  = c0 + 10;
      x  = w + 30;
      exp_vec(c0 + 4,  TICKS | SQS, 11'h000, "a_before_first_tick");
      exp_vec(c0 + 5,  TICKS | SQS, 11'h3FF, "a_tick_at_5");
      exp_vec(c0 + 6,  TICKS | SQS, 11'h3E0, "a_tick_one_cycle");
      exp_vec(c0 + 10, TICKS | SQS, 11'h01F, "a_tick_at_10");
      enable = '1;

      // Channel 1: write 3 mid-period (count=2)
      goto(w + 2);
      exp_ch(w + 5,  1, 1'b1, 1'b1, "b_ch1_old_period_end");
      exp_ch(w + 6,  1, 1'b0, 1'b1, "b_ch1_after_wrap");
      exp_ch(w + 7,  1, 1'b0, 1'b1, "b_ch1_no_tick_7");
      exp_ch(w + 8,  1, 1'b1, 1'b0, "b_ch1_new_mod3");
      exp_ch(w + 11, 1, 1'b1, 1'b1, "b_ch1_mod3_again");
      exp_ch(w + 8,  0, 1'b0, 1'b1, "b_ch0_undisturbed");
      exp_ch(w + 10, 0, 1'b1, 1'b0, "b_ch0_tick");
      exp_ch(w + 10, 3, 1'b1, 1'b0, "b_ch3_tick");
      wr(1, 3);
      at_posedge();
      load = 1'b0;

      // Channel 2: write 8 on its own wrap edge
      goto(w + 14);
      exp_ch(w + 15, 2, 1'b1, 1'b1, "c_ch2_wrap_on_write");
      exp_ch(w + 20, 2, 1'b1, 1'b0, "c_ch2_one_more_old");
      exp_ch(w + 25, 2, 1'b0, 1'b0, "c_ch2_not_at_25");
      exp_ch(w + 27, 2, 1'b0, 1'b0, "c_ch2_not_at_27");
      exp_ch(w + 28, 2, 1'b1, 1'b1, "c_ch2_mod8");
      exp_ch(w + 25, 0, 1'b1, 1'b1, "c_ch0_phase");
      exp_ch(w + 30, 0, 1'b1, 1'b0, "c_ch0_phase2");
      wr(2, 8);
      at_posedge();
      load = 1'b0;

      // Channel 0: disable mid-period, write 2 while disabled, re-enable, then modulus 1
      goto(x + 1);
      exp_ch(x + 2,  0, 1'b0, 1'b0, "d_ch0_disabled");
      exp_ch(x + 5,  0, 1'b0, 1'b0, "d_ch0_still_off");
      exp_tick(x + 5, 1, 1'b1, "d_ch1_unaffected");
      exp_ch(x + 7,  0, 1'b0, 1'b0, "d_ch0_count_cleared");
      exp_ch(x + 8,  0, 1'b1, 1'b1, "d_ch0_mod2_tick");
      exp_ch(x + 9,  0, 1'b0, 1'b1, "d_ch0_mod2_gap");
      exp_ch(x + 10, 0, 1'b1, 1'b0, "d_ch0_mod2_tick2");
      enable = 5'b11110;
      goto(x + 3);
      wr(0, 2);
      goto(x + 4);
      load = 1'b0;
      goto(x + 6);
      enable = '1;
      goto(x + 10);
      exp_ch(x + 11, 0, 1'b0, 1'b0, "d_ch0_finish_mod2");
      exp_ch(x + 12, 0, 1'b1, 1'b1, "d_ch0_mod1_start");
      exp_ch(x + 13, 0, 1'b1, 1'b0, "d_ch0_mod1_cont");
      exp_ch(x + 14, 0, 1'b1, 1'b1, "d_ch0_mod1_cont2");
      exp_tick(x + 15, 0, 1'b1, "d_ch0_mod1_cont3");
      wr(0, 1);
      goto(x + 11);
      load = 1'b0;

      // Out-of-range channel write
      goto(x + 16);
      exp_vec(x + 16, ERR, 11'h000, "e_err_clear_before");
      exp_vec(x + 17, ERR, ERR,     "e_err_bad_channel");
      exp_tick(x + 21, 2, 1'b0, "e_ch2_no_early_tick");
      exp_tick(x + 22, 2, 1'b1, "e_ch2_mod_kept");
      wr(NCH, 7);
      goto(x + 17);
      load = 1'b0;

      // Pending write on channel 3, then sync_clear with a direct load on channel 4
      goto(x + 21);
      exp_vec(x + 24, TICKS | SQS | ERR, ERR, "f_clear_outputs_err_kept");
      exp_ch(x + 27, 3, 1'b0, 1'b0, "f_ch3_no_tick_27");
      exp_ch(x + 28, 3, 1'b1, 1'b1, "f_ch3_mod4");
      exp_ch(x + 32, 3, 1'b1, 1'b0, "f_ch3_mod4_again");
      exp_ch(x + 25, 4, 1'b0, 1'b0, "f_ch4_no_tick_25");
      exp_ch(x + 26, 4, 1'b1, 1'b1, "f_ch4_direct_mod2");
      exp_ch(x + 28, 4, 1'b1, 1'b0, "f_ch4_mod2_again");
      exp_tick(x + 25, 0, 1'b1, "f_ch0_mod1_after_clear");
      exp_tick(x + 26, 1, 1'b0, "f_ch1_no_tick_26");
      exp_tick(x + 27, 1, 1'b1, "f_ch1_mod3_after_clear");
      exp_tick(x + 31, 2, 1'b0, "f_ch2_no_tick_31");
      exp_tick(x + 32, 2, 1'b1, "f_ch2_mod8_after_clear");
      wr(3, 4);
      goto(x + 22);
      load = 1'b0;
      goto(x + 23);
      sync_clear = 1'b1;
      wr(4, 2);
      goto(x + 24);
      sync_clear = 1'b0;
      load       = 1'b0;

      // Pending write on channel 1, then asynchronous reset mid-period
      goto(x + 33);
      wr(1, 7);
      goto(x + 34);
      load = 1'b0;
      exp_vec(x + 34, ALL, 11'h000, "g_async_reset");
      exp_vec(x + 35, ALL, 11'h000, "g_held_in_reset");
      exp_vec(x + 39, TICKS | SQS, 11'h000, "g_no_tick_before_5");
      exp_vec(x + 40, ALL, 11'h3FF, "g_default_mod_restored");
      exp_tick(x + 45, 1, 1'b1, "g_ch1_pending_discarded");
      exp_tick(x + 45, 2, 1'b1, "g_ch2_default_mod");
      #1 reset_n = 1'b0;
      goto(x + 35);
      reset_n = 1'b1;

      // Zero-value write, then sync_clear keeps load_err
      goto(x + 41);
      exp_vec(x + 41, ERR, 11'h000, "h_err_clear_after_reset");
      exp_vec(x + 42, ERR, ERR,     "h_err_zero_value");
      wr(2, 0);
      goto(x + 42);
      load = 1'b0;
      goto(x + 46);
      exp_vec(x + 47, ALL, ERR,     "h_clear_keeps_err");
      exp_vec(x + 52, ALL, 11'h7FF, "h_ticks_after_clear");
      sync_clear = 1'b1;
      goto(x + 47);
      sync_clear = 1'b0;

      goto(x + 55);
      foreach (exp_q[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: expectation for cycle %0d never checked", exp_q[i].name, exp_q[i].cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
